// File: rtl/huffman_bit_aligner_if.sv
// Handshake bundle between the word feeder, the bit aligner and the Huffman decoder.
// slave = aligner side, master = feeder/decoder side.
interface huffman_bit_aligner_if #(
    parameter int WORD_W = 32,
    parameter int WIN_W  = 6,
    parameter int LEN_W  = 4,
    parameter int NB_W   = 6
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic [NB_W-1:0]   in_nbits;
    logic              in_ready;
    logic [WIN_W-1:0]  enc_data;
    logic              enc_load;
    logic              dec_ready;
    logic [LEN_W-1:0]  dec_symbol_length;

    modport slave (
        input  in_data, in_valid, in_last, in_nbits, dec_ready, dec_symbol_length,
        output in_ready, enc_data, enc_load
    );

    modport master (
        output in_data, in_valid, in_last, in_nbits, dec_ready, dec_symbol_length,
        input  in_ready, enc_data, enc_load
    );
endinterface

// File: rtl/huffman_bit_aligner.sv
// Bit aligner feeding a Huffman decoder: buffers MSB-first words, presents a WIN_W window,
// drops each decoded symbol's length. ALIGNER_STATS_EN adds a sym_count output.
module huffman_bit_aligner #(
    parameter int WORD_W = 32,
    parameter int BUF_W  = 64,
    parameter int WIN_W  = 6,
    parameter int LEN_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    huffman_bit_aligner_if.slave bus,
    output logic                 stream_done,
    output logic                 underflow
`ifdef ALIGNER_STATS_EN
    ,
    output logic [15:0]          sym_count
`endif
);
    localparam int CNT_W = $clog2(BUF_W + 1);

    typedef enum logic [2:0] {FILL, LOAD, WAIT, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [BUF_W-1:0] bit_buf, buf_app;
    logic [CNT_W-1:0] count, cnt_app, add_bits, len_ext;
    logic [LEN_W-1:0] len_q;
    logic             last_seen, accept, len_ok;

    assign bus.enc_data = bit_buf[BUF_W-1 -: WIN_W];
    assign bus.in_ready = !last_seen && (count <= CNT_W'(BUF_W - WORD_W)) && (state != SHIFT);
    assign accept       = bus.in_valid && bus.in_ready;
    // Out-of-range lengths (decoder idle/reset values) must not consume bits.
    assign len_ok       = bus.dec_ready && (bus.dec_symbol_length != '0) &&
                          (bus.dec_symbol_length <= LEN_W'(WIN_W));
    assign len_ext      = CNT_W'(len_q);
    assign add_bits     = bus.in_last ? CNT_W'(bus.in_nbits) : CNT_W'(WORD_W);
    assign cnt_app      = count + add_bits;

    // New word lands just below the valid bits; anything past the new count is cleared so
    // the padded window of a short last word reads as zeros.
    assign buf_app = (bit_buf | ({bus.in_data, {(BUF_W-WORD_W){1'b0}}} >> count)) &
                     ~({BUF_W{1'b1}} >> cnt_app);

    always_ff @(posedge clk) begin
        if (!rst) state <= FILL;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.enc_load = 1'b0;
        stream_done  = 1'b0;
        case (state)
            FILL: begin
                if (count >= CNT_W'(WIN_W) || (last_seen && count != '0)) state_nxt = LOAD;
                else if (last_seen)                                        state_nxt = DONE;
            end
            LOAD: begin
                bus.enc_load = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT:  if (len_ok) state_nxt = SHIFT;
            SHIFT: state_nxt = FILL;
            DONE: begin
                stream_done = 1'b1;
                state_nxt   = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_buf   <= '0;
            count     <= '0;
            last_seen <= 1'b0;
            len_q     <= '0;
            underflow <= 1'b0;
        end else begin
            // in_ready is low in SHIFT, so shift and append never collide.
            if (state == SHIFT) begin
                bit_buf <= bit_buf << len_q;
                if (len_ext > count) begin
                    count     <= '0;
                    underflow <= 1'b1;
                end else begin
                    count <= count - len_ext;
                end
            end else if (accept) begin
                bit_buf <= buf_app;
                count   <= cnt_app;
                if (bus.in_last) last_seen <= 1'b1;
            end
            if (state == DONE) last_seen <= 1'b0;
            if (state == WAIT && len_ok) len_q <= bus.dec_symbol_length;
        end
    end

`ifdef ALIGNER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst)                sym_count <= '0;
        else if (state == SHIFT) sym_count <= sym_count + 16'd1;
        else if (state == DONE)  sym_count <= '0;
    end
`else
    // Symbol statistics are not built in this configuration.
`endif
endmodule

// File: tb/tb_huffman_bit_aligner.sv
// Scoreboard bench for huffman_bit_aligner: a bit-queue model predicts each load window.
module tb_huffman_bit_aligner;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stream_done, underflow;
`ifdef ALIGNER_STATS_EN
    logic [15:0] sym_count;
`endif
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [5:0]  got_q[$];
    logic [5:0]  exp_q[$];
    logic [63:0] mbuf = '0;
    int          mcnt = 0;

    huffman_bit_aligner_if bus ();

    huffman_bit_aligner dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .stream_done (stream_done),
        .underflow   (underflow)
`ifdef ALIGNER_STATS_EN
        ,
        .sym_count   (sym_count)
`endif
    );

    always #5 clk = ~clk;

    // Every wait goes through here so no load or done pulse is missed.
    task automatic step();
        @(negedge clk);
        if (bus.enc_load) got_q.push_back(bus.enc_data);
        if (stream_done) done_cnt++;
    endtask

    task automatic model_push(input logic [31:0] d, input bit last, input int nb);
        logic [31:0] w;
        int n;
        n = last ? nb : 32;
        w = d & ~(32'hFFFF_FFFF >> n);
        mbuf = mbuf | ({w, 32'h0} >> mcnt);
        mcnt += n;
    endtask

    task automatic push_word(input logic [31:0] d, input bit last, input int nb);
        int n = 0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_nbits = 6'(nb);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin step(); n++; end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL push_ready: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end else begin
            model_push(d, last, nb);
        end
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_window();
        exp_q.push_back(mbuf[63:58]);
    endtask

    task automatic get_load(output logic [5:0] d, output logic [5:0] e, output bit ok, output int cyc);
        cyc = 0;
        while (got_q.size() == 0 && cyc < 20) begin step(); cyc++; end
        ok = (got_q.size() != 0) && (exp_q.size() != 0);
        d = 6'h0;
        e = 6'h0;
        if (got_q.size() != 0) d = got_q.pop_front();
        if (exp_q.size() != 0) e = exp_q.pop_front();
    endtask

    task automatic consume(input int len);
        step();
        bus.dec_ready = 1'b1;
        bus.dec_symbol_length = 4'(len);
        step();
        bus.dec_ready = 1'b0;
        bus.dec_symbol_length = 4'd0;
        mbuf = mbuf << len;
        mcnt = (len > mcnt) ? 0 : mcnt - len;
    endtask

    task automatic reset_low();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.in_nbits = 6'd0;
        bus.in_data = 32'h0;
        bus.dec_ready = 1'b0;
        bus.dec_symbol_length = 4'd0;
        step();
        step();
    endtask

    task automatic reset_release();
        rst = 1'b1;
        got_q.delete();
        exp_q.delete();
        mbuf = '0;
        mcnt = 0;
    endtask

    task automatic test_reset();
        reset_low();
        checks += 5;
        if (bus.in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready: got %b need 1", bus.in_ready); end
        if (bus.enc_load !== 1'b0)    begin errors++; $display("FAIL reset_enc_load: got %b need 0", bus.enc_load); end
        if (stream_done !== 1'b0)     begin errors++; $display("FAIL reset_stream_done: got %b need 0", stream_done); end
        if (underflow !== 1'b0)       begin errors++; $display("FAIL reset_underflow: got %b need 0", underflow); end
        if (bus.enc_data !== 6'h0)    begin errors++; $display("FAIL reset_enc_data: got %b need 000000", bus.enc_data); end
`ifdef ALIGNER_STATS_EN
        checks++;
        if (sym_count !== 16'h0)      begin errors++; $display("FAIL reset_sym_count: got %0d need 0", sym_count); end
`endif
        reset_release();
    endtask

    task automatic test_basic();
        logic [5:0] d, e;
        bit ok;
        int cyc;
        reset_low(); reset_release();
        push_word(32'hFC00_0000, 1'b0, 0);
        expect_window();
        get_load(d, e, ok, cyc);
        checks += 2;
        if (!ok || d !== e) begin errors++; $display("FAIL basic_first_window: got %b need %b (ok=%0d)", d, e, ok); end
        if (cyc != 1) begin errors++; $display("FAIL basic_first_latency: got %0d steps need 1", cyc); end
        consume(1);
        expect_window();
        get_load(d, e, ok, cyc);
        checks += 2;
        if (!ok || d !== e) begin errors++; $display("FAIL basic_len1_window: got %b need %b (ok=%0d)", d, e, ok); end
        if (cyc != 2) begin errors++; $display("FAIL basic_len1_latency: got %0d steps need 2", cyc); end
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_count31_ready: got %b need 1", bus.in_ready); end
    endtask

    task automatic test_last_word();
        logic [5:0] d, e;
        bit ok;
        int cyc, base;
        reset_low(); reset_release();
        push_word(32'h6800_0000, 1'b1, 8);
        expect_window();
        get_load(d, e, ok, cyc);
        checks++;
        if (!ok || d !== e) begin errors++; $display("FAIL last_window: got %b need %b (ok=%0d)", d, e, ok); end
        consume(5);
        expect_window();
        get_load(d, e, ok, cyc);
        checks++;
        if (!ok || d !== e) begin errors++; $display("FAIL last_padded_window: got %b need %b (ok=%0d)", d, e, ok); end
        consume(4);
        base = done_cnt;
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL last_underflow_early: got %b need 0", underflow); end
        step();
        checks += 2;
        if (underflow !== 1'b1) begin errors++; $display("FAIL last_underflow: got %b need 1", underflow); end
        if (stream_done !== 1'b0) begin errors++; $display("FAIL last_done_early: got %b need 0", stream_done); end
        step();
        checks += 2;
        if (stream_done !== 1'b1) begin errors++; $display("FAIL last_done_pulse: got %b need 1", stream_done); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL last_done_ready: got %b need 0", bus.in_ready); end
        step();
        checks += 4;
        if (stream_done !== 1'b0) begin errors++; $display("FAIL last_done_width: got %b need 0", stream_done); end
        if (done_cnt != base + 1) begin errors++; $display("FAIL last_done_count: got %0d need %0d", done_cnt, base + 1); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL last_restart_ready: got %b need 1", bus.in_ready); end
        if (got_q.size() != 0) begin errors++; $display("FAIL last_extra_load: got %0d loads need 0", got_q.size()); end
    endtask

    task automatic test_ignore_len();
        logic [5:0] d, e;
        bit ok;
        int cyc;
        reset_low(); reset_release();
        push_word(32'hA500_0000, 1'b0, 0);
        expect_window();
        get_load(d, e, ok, cyc);
        checks++;
        if (!ok || d !== e) begin errors++; $display("FAIL ignore_first_window: got %b need %b (ok=%0d)", d, e, ok); end
        step();
        bus.dec_ready = 1'b1;
        bus.dec_symbol_length = 4'd10;
        step();
        bus.dec_symbol_length = 4'd0;
        step();
        bus.dec_ready = 1'b0;
        repeat (6) step();
        checks += 2;
        if (got_q.size() != 0) begin errors++; $display("FAIL ignore_no_load: got %0d loads need 0", got_q.size()); end
        if (bus.enc_data !== mbuf[63:58]) begin errors++; $display("FAIL ignore_window_hold: got %b need %b", bus.enc_data, mbuf[63:58]); end
        consume(2);
        expect_window();
        get_load(d, e, ok, cyc);
        checks++;
        if (!ok || d !== e) begin errors++; $display("FAIL ignore_after_window: got %b need %b (ok=%0d)", d, e, ok); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] d, e;
        bit ok;
        int cyc;
        reset_low(); reset_release();
        push_word(32'h1234_5678, 1'b0, 0);
        push_word(32'h9ABC_DEF0, 1'b0, 0);
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b need 0", bus.in_ready); end
        expect_window();
        get_load(d, e, ok, cyc);
        checks++;
        if (!ok || d !== e) begin errors++; $display("FAIL b2b_window0: got %b need %b (ok=%0d)", d, e, ok); end
        for (int i = 0; i < 6; i++) begin
            consume(6);
            expect_window();
            get_load(d, e, ok, cyc);
            step();
            checks += 2;
            if (!ok || d !== e) begin errors++; $display("FAIL b2b_window%0d: got %b need %b (ok=%0d)", i + 1, d, e, ok); end
            if (bus.in_ready !== (mcnt <= 32)) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b need %b (count %0d)", i + 1, bus.in_ready, (mcnt <= 32), mcnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] d, e;
        bit ok;
        int cyc;
        reset_low(); reset_release();
        push_word(32'hFFFF_FFFF, 1'b0, 0);
        push_word(32'hFF80_0000, 1'b1, 9);
        expect_window();
        get_load(d, e, ok, cyc);
        consume(1);
        expect_window();
        get_load(d, e, ok, cyc);
        step();
        checks++;
        if (!ok || d !== e) begin errors++; $display("FAIL mid_window: got %b need %b (ok=%0d)", d, e, ok); end
`ifdef ALIGNER_STATS_EN
        checks++;
        if (sym_count !== 16'd1) begin errors++; $display("FAIL mid_sym_count_pre: got %0d need 1", sym_count); end
`endif
        rst = 1'b0;
        step();
        checks += 3;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b need 1", bus.in_ready); end
        if (bus.enc_load !== 1'b0) begin errors++; $display("FAIL mid_rst_load: got %b need 0", bus.enc_load); end
        if (bus.enc_data !== 6'h0) begin errors++; $display("FAIL mid_rst_data: got %b need 000000", bus.enc_data); end
`ifdef ALIGNER_STATS_EN
        checks++;
        if (sym_count !== 16'd0) begin errors++; $display("FAIL mid_sym_count: got %0d need 0", sym_count); end
`endif
        reset_release();
        repeat (5) step();
        checks += 2;
        if (got_q.size() != 0) begin errors++; $display("FAIL mid_no_load: got %0d loads need 0", got_q.size()); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_idle_ready: got %b need 1", bus.in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_last_word();
        test_ignore_len();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
